// File: rtl/regfile_access_ctrl.sv
// Operand-fetch / writeback sequencer for a single-port register file with a busy scoreboard.
// Optional feature: define REGFILE_ACCESS_BYPASS_EN to forward writeback data to operands in CHECK.
module regfile_access_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  // decode request
  input  logic            i_dec_valid,
  output logic            o_dec_ready,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  input  logic [4:0]      i_dec_rd,
  input  logic            i_dec_rd_we,
  // operands toward execute
  output logic            o_opnd_valid,
  input  logic            i_opnd_ready,
  output logic [XLEN-1:0] o_opnd_a,
  output logic [XLEN-1:0] o_opnd_b,
  output logic [4:0]      o_opnd_rd,
  output logic            o_opnd_rd_we,
  // writeback
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_val,
  // register file port
  output logic            o_rf_en,
  output logic            o_rf_op,
  output logic [4:0]      o_rf_reg_num_1,
  output logic [4:0]      o_rf_reg_num_2,
  output logic [4:0]      o_rf_reg_num,
  output logic [XLEN-1:0] o_rf_val,
  input  logic [XLEN-1:0] i_rf_rs_1,
  input  logic [XLEN-1:0] i_rf_rs_2
);

  typedef enum logic [1:0] {StIdle, StCheck, StCapture, StHold} state_e;

  state_e            r_state, w_state_d;
  logic [4:0]        r_rs1, w_rs1_d;
  logic [4:0]        r_rs2, w_rs2_d;
  logic [4:0]        r_rd, w_rd_d;
  logic              r_rd_we, w_rd_we_d;
  logic [NREG-1:0]   r_busy, w_busy_d;
  logic [XLEN-1:0]   r_opnd_a, w_opnd_a_d;
  logic [XLEN-1:0]   r_opnd_b, w_opnd_b_d;

  logic              w_wb_hit;
  logic              w_haz_a, w_haz_b;
  logic              w_block_a, w_block_b;
  logic              w_rd_issue;

  // A writeback to x0 is architecturally void: no port use, no scoreboard change.
  assign w_wb_hit = i_rst_n && i_wb_valid && (i_wb_rd != 5'd0);
  assign w_haz_a  = (r_rs1 != 5'd0) && r_busy[r_rs1];
  assign w_haz_b  = (r_rs2 != 5'd0) && r_busy[r_rs2];

`ifdef REGFILE_ACCESS_BYPASS_EN
  logic r_ok_a, w_ok_a_d;
  logic r_ok_b, w_ok_b_d;
  logic w_fwd_a, w_fwd_b;

  // An operand already taken from the writeback bus no longer needs the port or a clean busy bit.
  assign w_fwd_a   = !r_ok_a && w_wb_hit && (i_wb_rd == r_rs1);
  assign w_fwd_b   = !r_ok_b && w_wb_hit && (i_wb_rd == r_rs2);
  assign w_block_a = !r_ok_a && w_haz_a && !w_fwd_a;
  assign w_block_b = !r_ok_b && w_haz_b && !w_fwd_b;
`else
  assign w_block_a = w_haz_a;
  assign w_block_b = w_haz_b;
`endif

  assign w_rd_issue = i_rst_n && (r_state == StCheck) && !w_block_a && !w_block_b && !i_wb_valid;

  always_comb begin
    w_state_d  = r_state;
    w_rs1_d    = r_rs1;
    w_rs2_d    = r_rs2;
    w_rd_d     = r_rd;
    w_rd_we_d  = r_rd_we;
    w_busy_d   = r_busy;
    w_opnd_a_d = r_opnd_a;
    w_opnd_b_d = r_opnd_b;
`ifdef REGFILE_ACCESS_BYPASS_EN
    w_ok_a_d   = r_ok_a;
    w_ok_b_d   = r_ok_b;
`endif

    if (w_wb_hit) begin
      w_busy_d[i_wb_rd] = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (i_dec_valid) begin
          w_rs1_d   = i_dec_rs1;
          w_rs2_d   = i_dec_rs2;
          w_rd_d    = i_dec_rd;
          w_rd_we_d = i_dec_rd_we;
`ifdef REGFILE_ACCESS_BYPASS_EN
          w_ok_a_d  = 1'b0;
          w_ok_b_d  = 1'b0;
`endif
          w_state_d = StCheck;
        end
      end
      StCheck: begin
`ifdef REGFILE_ACCESS_BYPASS_EN
        if (!w_block_a && !w_block_b) begin
          if (w_fwd_a) begin
            w_ok_a_d   = 1'b1;
            w_opnd_a_d = i_wb_val;
          end
          if (w_fwd_b) begin
            w_ok_b_d   = 1'b1;
            w_opnd_b_d = i_wb_val;
          end
        end
        if (!w_block_a && !w_block_b && (r_ok_a || w_fwd_a) && (r_ok_b || w_fwd_b)) begin
          w_state_d = StHold;
        end else if (w_rd_issue) begin
          w_state_d = StCapture;
        end
`else
        if (w_rd_issue) begin
          w_state_d = StCapture;
        end
`endif
      end
      StCapture: begin
`ifdef REGFILE_ACCESS_BYPASS_EN
        if (!r_ok_a) w_opnd_a_d = (r_rs1 == 5'd0) ? '0 : i_rf_rs_1;
        if (!r_ok_b) w_opnd_b_d = (r_rs2 == 5'd0) ? '0 : i_rf_rs_2;
`else
        w_opnd_a_d = (r_rs1 == 5'd0) ? '0 : i_rf_rs_1;
        w_opnd_b_d = (r_rs2 == 5'd0) ? '0 : i_rf_rs_2;
`endif
        w_state_d = StHold;
      end
      StHold: begin
        if (i_opnd_ready) begin
          // Applied after the writeback clear so the newer instruction's claim wins.
          if (r_rd_we && (r_rd != 5'd0)) begin
            w_busy_d[r_rd] = 1'b1;
          end
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_rd     <= 5'd0;
      r_rd_we  <= 1'b0;
      r_busy   <= '0;
      r_opnd_a <= '0;
      r_opnd_b <= '0;
`ifdef REGFILE_ACCESS_BYPASS_EN
      r_ok_a   <= 1'b0;
      r_ok_b   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_rs1    <= w_rs1_d;
      r_rs2    <= w_rs2_d;
      r_rd     <= w_rd_d;
      r_rd_we  <= w_rd_we_d;
      r_busy   <= w_busy_d;
      r_opnd_a <= w_opnd_a_d;
      r_opnd_b <= w_opnd_b_d;
`ifdef REGFILE_ACCESS_BYPASS_EN
      r_ok_a   <= w_ok_a_d;
      r_ok_b   <= w_ok_b_d;
`endif
    end
  end

  // Handshake outputs are gated by reset so nothing is offered or accepted in a reset cycle.
  assign o_dec_ready  = i_rst_n && (r_state == StIdle);
  assign o_opnd_valid = i_rst_n && (r_state == StHold);
  assign o_opnd_a     = r_opnd_a;
  assign o_opnd_b     = r_opnd_b;
  assign o_opnd_rd    = r_rd;
  assign o_opnd_rd_we = r_rd_we;

  always_comb begin
    o_rf_en        = 1'b0;
    o_rf_op        = 1'b0;
    o_rf_reg_num_1 = 5'd0;
    o_rf_reg_num_2 = 5'd0;
    o_rf_reg_num   = 5'd0;
    o_rf_val       = '0;
    if (w_wb_hit) begin
      o_rf_en      = 1'b1;
      o_rf_op      = 1'b1;
      o_rf_reg_num = i_wb_rd;
      o_rf_val     = i_wb_val;
    end else if (w_rd_issue) begin
      o_rf_en        = 1'b1;
      o_rf_reg_num_1 = r_rs1;
      o_rf_reg_num_2 = r_rs2;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl (default build): vector table plus
// hand-written hazard, writeback-priority, reset and scoreboard sequences.
module tb_regfile_access_ctrl;
  localparam int unsigned XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_dec_valid;
  logic            o_dec_ready;
  logic [4:0]      i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic            i_dec_rd_we;
  logic            o_opnd_valid;
  logic            i_opnd_ready;
  logic [XLEN-1:0] o_opnd_a, o_opnd_b;
  logic [4:0]      o_opnd_rd;
  logic            o_opnd_rd_we;
  logic            i_wb_valid;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_val;
  logic            o_rf_en, o_rf_op;
  logic [4:0]      o_rf_reg_num_1, o_rf_reg_num_2, o_rf_reg_num;
  logic [XLEN-1:0] o_rf_val;
  logic [XLEN-1:0] i_rf_rs_1, i_rf_rs_2;

  regfile_access_ctrl #(.XLEN(XLEN), .NREG(32)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_dec_valid    (i_dec_valid),
    .o_dec_ready    (o_dec_ready),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .i_dec_rd       (i_dec_rd),
    .i_dec_rd_we    (i_dec_rd_we),
    .o_opnd_valid   (o_opnd_valid),
    .i_opnd_ready   (i_opnd_ready),
    .o_opnd_a       (o_opnd_a),
    .o_opnd_b       (o_opnd_b),
    .o_opnd_rd      (o_opnd_rd),
    .o_opnd_rd_we   (o_opnd_rd_we),
    .i_wb_valid     (i_wb_valid),
    .i_wb_rd        (i_wb_rd),
    .i_wb_val       (i_wb_val),
    .o_rf_en        (o_rf_en),
    .o_rf_op        (o_rf_op),
    .o_rf_reg_num_1 (o_rf_reg_num_1),
    .o_rf_reg_num_2 (o_rf_reg_num_2),
    .o_rf_reg_num   (o_rf_reg_num),
    .o_rf_val       (o_rf_val),
    .i_rf_rs_1      (i_rf_rs_1),
    .i_rf_rs_2      (i_rf_rs_2)
  );

  always #5 i_clk = ~i_clk;

  // Register file model: one-cycle read latency; x0 holds junk so zero-forcing is visible.
  logic [XLEN-1:0] rf_mem [32];
  logic [XLEN-1:0] rf_rd1 = '0, rf_rd2 = '0;
  always @(posedge i_clk) begin
    if (o_rf_en && o_rf_op) rf_mem[o_rf_reg_num] <= o_rf_val;
    if (o_rf_en && !o_rf_op) begin
      rf_rd1 <= rf_mem[o_rf_reg_num_1];
      rf_rd2 <= rf_mem[o_rf_reg_num_2];
    end
  end
  assign i_rf_rs_1 = rf_rd1;
  assign i_rf_rs_2 = rf_rd2;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Each cycle: drive at posedge+1, check at posedge+2.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we);
    i_dec_valid = 1'b1;
    i_dec_rs1   = rs1;
    i_dec_rs2   = rs2;
    i_dec_rd    = rd;
    i_dec_rd_we = we;
    #1;
    chk1("dec_ready_idle", o_dec_ready, 1'b1);
    tick();
    // Junk on the bus afterwards: must not be resampled.
    i_dec_valid = 1'b0;
    i_dec_rs1   = 5'd31;
    i_dec_rs2   = 5'd31;
    i_dec_rd    = 5'd30;
    i_dec_rd_we = 1'b1;
  endtask

  task automatic expect_read(input logic [4:0] rs1, input logic [4:0] rs2);
    #1;
    chk1("read_en", o_rf_en, 1'b1);
    chk1("read_op", o_rf_op, 1'b0);
    chk5("read_num_1", o_rf_reg_num_1, rs1);
    chk5("read_num_2", o_rf_reg_num_2, rs2);
    chk1("dec_ready_busy", o_dec_ready, 1'b0);
    tick();
  endtask

  task automatic expect_stall();
    #1;
    chk1("stall_no_access", o_rf_en, 1'b0);
    chk1("stall_dec_ready", o_dec_ready, 1'b0);
    chk1("stall_valid", o_opnd_valid, 1'b0);
    tick();
  endtask

  task automatic expect_capture();
    #1;
    chk1("capture_valid_low", o_opnd_valid, 1'b0);
    tick();
  endtask

  task automatic expect_hold(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                             input logic we);
    #1;
    chk1("hold_valid", o_opnd_valid, 1'b1);
    chk32("opnd_a", o_opnd_a, a);
    chk32("opnd_b", o_opnd_b, b);
    chk5("opnd_rd", o_opnd_rd, rd);
    chk1("opnd_rd_we", o_opnd_rd_we, we);
    i_opnd_ready = 1'b1;
    tick();
    i_opnd_ready = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    i_wb_valid = 1'b1;
    i_wb_rd    = rd;
    i_wb_val   = val;
    #1;
    if (rd != 5'd0) begin
      chk1("wb_en", o_rf_en, 1'b1);
      chk1("wb_op", o_rf_op, 1'b1);
      chk5("wb_num", o_rf_reg_num, rd);
      chk32("wb_val", o_rf_val, val);
    end else begin
      chk1("wb_x0_no_access", o_rf_en, 1'b0);
    end
    tick();
    i_wb_valid = 1'b0;
    i_wb_rd    = 5'd0;
    i_wb_val   = '0;
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hDEAD_0000 + 32'(i);
    vecs[0] = '{5'd3,  5'd4,  5'd1, 32'h0000_0011, 32'h0000_0022};
    vecs[1] = '{5'd0,  5'd0,  5'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{5'd4,  5'd3,  5'd3, 32'h0000_0022, 32'h0000_0011};
    vecs[3] = '{5'd31, 5'd0,  5'd4, 32'hFFFF_0000, 32'h0000_0000};
    vecs[4] = '{5'd6,  5'd6,  5'd5, 32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{5'd0,  5'd31, 5'd6, 32'h0000_0000, 32'hFFFF_0000};

    i_rst_n = 1'b0;  i_dec_valid = 1'b0; i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_rd = '0;
    i_dec_rd_we = 1'b0; i_opnd_ready = 1'b0; i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_val = '0;

    // Reset state
    tick();
    #1;
    chk1("rst_dec_ready", o_dec_ready, 1'b0);
    chk1("rst_rf_en", o_rf_en, 1'b0);
    chk1("rst_valid", o_opnd_valid, 1'b0);
    chk32("rst_opnd_a", o_opnd_a, 32'h0);
    chk32("rst_opnd_b", o_opnd_b, 32'h0);
    chk5("rst_opnd_rd", o_opnd_rd, 5'd0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk1("post_rst_dec_ready", o_dec_ready, 1'b1);
    tick();

    // Preload through the writeback path; x0 writes must not touch the port
    wb(5'd3,  32'h0000_0011);
    wb(5'd4,  32'h0000_0022);
    wb(5'd6,  32'h1234_5678);
    wb(5'd31, 32'hFFFF_0000);
    wb(5'd0,  32'h5555_5555);

    // Table: minimum-latency requests without destination writes
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 1'b0);
      expect_read(vecs[i].rs1, vecs[i].rs2);
      expect_capture();
      expect_hold(vecs[i].exp_a, vecs[i].exp_b, vecs[i].rd, 1'b0);
    end

    // RAW hazard on x5: stall until its writeback, read the cycle after
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    expect_read(5'd0, 5'd0);
    expect_capture();
    expect_hold(32'h0, 32'h0, 5'd5, 1'b1);
    issue(5'd5, 5'd3, 5'd0, 1'b0);
    expect_stall();
    expect_stall();
    expect_stall();
    wb(5'd5, 32'h0000_ABCD);
    expect_read(5'd5, 5'd3);
    expect_capture();
    expect_hold(32'h0000_ABCD, 32'h0000_0011, 5'd0, 1'b0);

    // Writebacks hold the port for three CHECK cycles
    issue(5'd3, 5'd4, 5'd0, 1'b0);
    wb(5'd10, 32'h0000_00A0);
    wb(5'd11, 32'h0000_00A1);
    wb(5'd12, 32'h0000_00A2);
    expect_read(5'd3, 5'd4);
    expect_capture();
    expect_hold(32'h0000_0011, 32'h0000_0022, 5'd0, 1'b0);

    // Busy set and cleared for x7 in the same cycle: set must win
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    expect_read(5'd0, 5'd0);
    expect_capture();
    #1;
    chk1("setclr_hold_valid", o_opnd_valid, 1'b1);
    i_opnd_ready = 1'b1;
    i_wb_valid   = 1'b1;
    i_wb_rd      = 5'd7;
    i_wb_val     = 32'h0000_0077;
    #1;
    chk1("setclr_wb_en", o_rf_en, 1'b1);
    chk1("setclr_wb_op", o_rf_op, 1'b1);
    tick();
    i_opnd_ready = 1'b0;
    i_wb_valid   = 1'b0;
    i_wb_rd      = 5'd0;
    i_wb_val     = '0;
    issue(5'd7, 5'd0, 5'd0, 1'b0);
    expect_stall();
    expect_stall();
    wb(5'd7, 32'h0000_0078);
    expect_read(5'd7, 5'd0);
    expect_capture();
    expect_hold(32'h0000_0078, 32'h0, 5'd0, 1'b0);

    // Reset in HOLD with a busy bit pending and a writeback on the bus
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    expect_read(5'd0, 5'd0);
    expect_capture();
    expect_hold(32'h0, 32'h0, 5'd9, 1'b1);
    issue(5'd3, 5'd4, 5'd8, 1'b1);
    expect_read(5'd3, 5'd4);
    expect_capture();
    #1;
    chk1("hold_stable_valid_0", o_opnd_valid, 1'b1);
    chk32("hold_stable_a_0", o_opnd_a, 32'h0000_0011);
    tick();
    #1;
    chk1("hold_stable_valid_1", o_opnd_valid, 1'b1);
    chk32("hold_stable_b_1", o_opnd_b, 32'h0000_0022);
    i_rst_n    = 1'b0;
    i_wb_valid = 1'b1;
    i_wb_rd    = 5'd3;
    i_wb_val   = 32'h0000_0099;
    #1;
    chk1("in_rst_rf_en", o_rf_en, 1'b0);
    chk1("in_rst_valid", o_opnd_valid, 1'b0);
    chk1("in_rst_dec_ready", o_dec_ready, 1'b0);
    tick();
    i_rst_n    = 1'b1;
    i_wb_valid = 1'b0;
    i_wb_rd    = 5'd0;
    i_wb_val   = '0;
    #1;
    chk1("after_rst_valid", o_opnd_valid, 1'b0);
    chk1("after_rst_dec_ready", o_dec_ready, 1'b1);
    chk1("after_rst_rf_en", o_rf_en, 1'b0);
    chk32("after_rst_opnd_a", o_opnd_a, 32'h0);
    chk5("after_rst_opnd_rd", o_opnd_rd, 5'd0);
    tick();
    // x9 was busy before reset; it must read immediately now
    issue(5'd9, 5'd3, 5'd0, 1'b0);
    expect_read(5'd9, 5'd3);
    expect_capture();
    expect_hold(32'hDEAD_0009, 32'h0000_0011, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
